// File: rtl/btn_mode_ctrl.sv
// btn_mode_ctrl: front-end control stage for the 10-LED bar/dot sequencer.
//   Synchronises and debounces a raw push-button. On each accepted press it toggles
//   the mode bit x and emits a 1-cycle press pulse. Independently, it emits a 1-cycle
//   step strobe every DIV clocks.
// Ports:
//   ck    in  system clock, all logic on posedge
//   rs    in  synchronous active-high reset
//   btn   in  raw asynchronous, bouncy push-button (1 = pressed)
//   x     out mode bit (0 = dot, 1 = bar)
//   press out 1-cycle pulse per accepted press
//   tick  out 1-cycle step strobe, period DIV
//   db    out debounced button level
module btn_mode_ctrl #(
  parameter int unsigned DEB_CYCLES = 250000,
  parameter int unsigned DIV        = 5000000
) (
  input  logic ck,
  input  logic rs,
  input  logic btn,
  output logic x,
  output logic press,
  output logic tick,
  output logic db
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES);
  localparam int unsigned DivW = $clog2(DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);
  localparam logic [DivW-1:0] DivMax = DivW'(DIV - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPWait   = 2'd1,
    StPressed = 2'd2,
    StRWait   = 2'd3
  } state_e;

  logic            s1_q, s2_q;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            x_q, x_d;
  logic            press_q, press_d;
  logic            db_q, db_d;
  logic [DivW-1:0] tcnt_q, tcnt_d;
  logic            tick_q, tick_d;

  // Debounce next-state: a level change is accepted only after DEB_CYCLES
  // consecutive agreeing samples of s2.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    press_d = 1'b0;
    db_d    = db_q;
    case (state_q)
      StIdle: begin
        db_d = 1'b0;
        if (s2_q) begin
          state_d = StPWait;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StPWait: begin
        if (!s2_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StPressed;
          cnt_d   = '0;
          db_d    = 1'b1;
          press_d = 1'b1;
          x_d     = ~x_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPressed: begin
        db_d = 1'b1;
        if (!s2_q) begin
          state_d = StRWait;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StRWait: begin
        if (s2_q) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
          cnt_d   = '0;
          db_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        db_d    = 1'b0;
      end
    endcase
  end

  // Free-running tick divider, independent of the button path.
  always_comb begin
    tick_d = (tcnt_q == DivMax);
    tcnt_d = tick_d ? '0 : tcnt_q + DivW'(1);
  end

  always_ff @(posedge ck) begin
    if (rs) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      press_q <= 1'b0;
      db_q    <= 1'b0;
      tcnt_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      press_q <= press_d;
      db_q    <= db_d;
      tcnt_q  <= tcnt_d;
      tick_q  <= tick_d;
    end
  end

  assign x     = x_q;
  assign press = press_q;
  assign tick  = tick_q;
  assign db    = db_q;

endmodule
